exponent_arbiter: RTL and testbench

EXPONENT_ARBITER -- requirements
Module: exponent_arbiter

---
 rtl/exponent_arbiter.sv | 170 +++++++++++++++++
 tb/tb_exponent_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exponent_arbiter.sv
// exponent_arbiter: round-robin front end that shares one in-order exponent
// engine between NREQ requesters. Each accepted operand is issued one cycle
// later, its owner is queued in a tag FIFO, and every engine result is
// steered back to the owner at the head of that FIFO one cycle after it
// arrives.
//
// Handshakes: a requester transfers when req_valid[i] && req_ready[i] in the
// same cycle; req_ready is combinational and never depends on the engine in
// the same cycle. The engine has no backpressure: eng_in_valid is a strobe,
// and eng_out_valid is always consumed.
module exponent_arbiter #(
    parameter int BITS         = 32,
    parameter     PRECISION    = "FIXED_16_16",
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*BITS-1:0]          req_a,
    output logic [NREQ-1:0]               req_ready,
    output logic                          eng_in_valid,
    output logic [BITS-1:0]               eng_a,
    input  logic                          eng_out_valid,
    input  logic [BITS-1:0]               eng_c,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [BITS-1:0]               rsp_c,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          idle,
    output logic                          err_orphan
);

    localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PTRW = $clog2(MAX_INFLIGHT);
    localparam int CNTW = PTRW + 1;

    // The number format only matters to the engine; here it must at least be
    // a text tag. Requester count and FIFO depth must stay in their legal range.
    if ((NREQ < 2) || (NREQ > 8) || (MAX_INFLIGHT < 2) || (MAX_INFLIGHT > 32) ||
        ((MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) || (($bits(PRECISION) % 8) != 0))
    begin : g_param_err
        $error("exponent_arbiter: unsupported parameter set");
    end

    logic [TAGW-1:0] last_grant;
    logic [TAGW-1:0] win_idx;
    logic            win_found;
    logic            full;
    logic            handshake;
    logic            pop;
    logic            orphan_hit;

    logic [TAGW-1:0] tag_mem [MAX_INFLIGHT];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [TAGW-1:0] head_tag;

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens a slot early.
    assign full       = (inflight == CNTW'(MAX_INFLIGHT));
    assign handshake  = |(req_valid & req_ready);
    assign pop        = eng_out_valid && (inflight != '0);
    assign orphan_hit = eng_out_valid && (inflight == '0);
    assign head_tag   = tag_mem[rd_ptr];
    assign idle       = (inflight == '0) && !eng_in_valid;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic [TAGW-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = TAGW'((int'(last_grant) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Only the winner sees ready, and only while a tag slot is free and out of reset.
    always_comb begin
        req_ready = '0;
        if (rstn && win_found && !full) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Remember who was granted last; reset value makes requester 0 first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= TAGW'(NREQ - 1);
        end else if (handshake) begin
            last_grant <= win_idx;
        end
    end

    // Register the accepted operand towards the engine (one-cycle issue).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eng_in_valid <= 1'b0;
            eng_a        <= '0;
        end else begin
            eng_in_valid <= handshake;
            if (handshake) begin
                eng_a <= req_a[int'(win_idx)*BITS +: BITS];
            end
        end
    end

    // Tag storage: owner index of each outstanding operation, in issue order.
    always_ff @(posedge clk) begin
        if (handshake) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (handshake) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
        end
    end

    // Outstanding count: up on accept, down on a matched result, both = hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
        end else begin
            case ({handshake, pop})
                2'b10:   inflight <= inflight + CNTW'(1);
                2'b01:   inflight <= inflight - CNTW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Steer each result to its owner one cycle after the engine delivers it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_c     <= '0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[head_tag] <= 1'b1;
                rsp_c               <= eng_c;
            end
        end
    end

    // A result with nothing outstanding is flagged until the next reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_orphan <= 1'b0;
        end else if (orphan_hit) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exponent_arbiter.sv
// Bench for exponent_arbiter: randomized and directed traffic against a
// queue-based reference of the arbiter plus a fixed-latency engine model.
module tb_exponent_arbiter;

    localparam int BITS         = 32;
    localparam int NREQ         = 4;
    localparam int MAX_INFLIGHT = 8;
    localparam int CNTW         = $clog2(MAX_INFLIGHT) + 1;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*BITS-1:0] req_a;
    logic [NREQ-1:0]      req_ready;
    logic                 eng_in_valid;
    logic [BITS-1:0]      eng_a;
    logic                 eng_out_valid;
    logic [BITS-1:0]      eng_c;
    logic [NREQ-1:0]      rsp_valid;
    logic [BITS-1:0]      rsp_c;
    logic [CNTW-1:0]      inflight;
    logic                 idle;
    logic                 err_orphan;

    exponent_arbiter #(
        .BITS(BITS), .PRECISION("FIXED_16_16"), .NREQ(NREQ), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
        .eng_in_valid(eng_in_valid), .eng_a(eng_a), .eng_out_valid(eng_out_valid),
        .eng_c(eng_c), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .inflight(inflight),
        .idle(idle), .err_orphan(err_orphan)
    );

    // ---------------- reference model state ----------------
    int              tag_q[$];       // owners of outstanding operations, oldest first
    logic [BITS-1:0] eng_dat[$];     // engine results still to be delivered
    int              eng_due[$];     // edge index at which each result is sampled
    int              m_last;
    logic            m_err;
    logic            exp_eiv;
    logic [BITS-1:0] exp_ea;
    logic [BITS-1:0] exp_rc;
    logic [NREQ-1:0] exp_rv;
    int              edge_n;
    int              lat;
    int              peak;
    int              hs_count;
    bit              use_fixed;
    logic [NREQ*BITS-1:0] fixed_a;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BITS-1:0] engine_fn(input logic [BITS-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
    endfunction

    // First requesting index after the last grant, or -1.
    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_regs();
        check("eng_in_valid", 64'(eng_in_valid), 64'(exp_eiv));
        check("eng_a",        64'(eng_a),        64'(exp_ea));
        check("rsp_valid",    64'(rsp_valid),    64'(exp_rv));
        check("rsp_c",        64'(rsp_c),        64'(exp_rc));
        check("inflight",     64'(inflight),     64'(tag_q.size()));
        check("idle",         64'(idle),         64'((tag_q.size() == 0) && !exp_eiv));
        check("err_orphan",   64'(err_orphan),   64'(m_err));
    endtask

    // ---------------- driver: one clock cycle, entered and left at negedge ----------------
    task automatic step(input logic [NREQ-1:0] v, input bit force_out);
        int              w;
        int              t;
        bit              hs;
        logic [NREQ-1:0] exp_ready;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_a[i*BITS +: BITS] = $urandom;
        if (use_fixed) req_a = fixed_a;
        if (eng_due.size() != 0 && eng_due[0] == edge_n + 1) begin
            eng_out_valid = 1'b1;
            eng_c         = eng_dat.pop_front();
            void'(eng_due.pop_front());
        end else begin
            eng_out_valid = force_out;
            eng_c         = $urandom;
        end
        #1;
        w         = pick(v);
        exp_ready = '0;
        if (w >= 0 && tag_q.size() < MAX_INFLIGHT) exp_ready[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        edge_n++;
        hs     = (exp_ready != '0);
        exp_rv = '0;
        if (eng_out_valid && tag_q.size() == 0) m_err = 1'b1;
        if (eng_out_valid && tag_q.size() != 0) begin
            t         = tag_q.pop_front();
            exp_rv[t] = 1'b1;
            exp_rc    = eng_c;
        end
        exp_eiv = hs;
        if (hs) begin
            exp_ea = req_a[w*BITS +: BITS];
            tag_q.push_back(w);
            m_last = w;
            hs_count++;
            eng_due.push_back(edge_n + 1 + lat);
            eng_dat.push_back(engine_fn(exp_ea));
        end
        if (tag_q.size() > peak) peak = tag_q.size();
        #1;
        check_regs();
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, hold for some edges.
    task automatic do_reset(input int edges);
        #2;
        rstn          = 1'b0;
        req_valid     = '1;
        eng_out_valid = 1'b0;
        #1;
        tag_q.delete();
        m_last  = NREQ - 1;
        m_err   = 1'b0;
        exp_eiv = 1'b0;
        exp_ea  = '0;
        exp_rc  = '0;
        exp_rv  = '0;
        check_regs();
        check("ready_in_reset", 64'(req_ready), 64'(0));
        repeat (edges) begin
            @(posedge clk);
            edge_n++;
            while (eng_due.size() != 0 && eng_due[0] <= edge_n) begin
                void'(eng_due.pop_front());
                void'(eng_dat.pop_front());
            end
        end
        @(negedge clk);
        check("ready_in_reset_hold", 64'(req_ready), 64'(0));
        rstn = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (tag_q.size() == 0 && eng_due.size() == 0) return;
            step('0, 1'b0);
        end
        check("drain_timeout", 64'(1), 64'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        req_valid     = '0;
        req_a         = '0;
        eng_out_valid = 1'b0;
        eng_c         = '0;
        m_last        = NREQ - 1;
        m_err         = 1'b0;
        exp_eiv       = 1'b0;
        exp_ea        = '0;
        exp_rc        = '0;
        exp_rv        = '0;
        edge_n        = 0;
        lat           = 5;
        peak          = 0;
        hs_count      = 0;
        use_fixed     = 1'b0;
        fixed_a       = '0;
        @(negedge clk);
        do_reset(2);

        // single operation, engine latency 5
        lat       = 5;
        fixed_a   = '0;
        fixed_a[BITS-1:0] = 32'h0001_0000;
        use_fixed = 1'b1;
        step(4'b0001, 1'b0);
        use_fixed = 1'b0;
        check("single_eng_a", 64'(eng_a), 64'(32'h0001_0000));
        drain();
        check("single_idle", 64'(idle), 64'(1));

        // fairness with all requesters active
        lat = 3;
        repeat (16) step(4'b1111, 1'b0);
        drain();

        // steady stream where push and pop coincide at inflight 3
        lat = 2;
        repeat (12) step(4'b0001, 1'b0);
        check("steady_inflight", 64'(inflight), 64'(3));
        drain();

        // fill to the limit with a slow engine
        lat      = 20;
        hs_count = 0;
        peak     = 0;
        repeat (20) step(4'b1111, 1'b0);
        check("full_handshakes", 64'(hs_count), 64'(MAX_INFLIGHT));
        check("full_peak", 64'(peak), 64'(MAX_INFLIGHT));
        repeat (30) step(4'b1111, 1'b0);
        drain();

        // orphan result
        step('0, 1'b1);
        check("orphan_set", 64'(err_orphan), 64'(1));
        repeat (3) step(4'($urandom_range(0, 15)), 1'b0);
        drain();
        check("orphan_sticky", 64'(err_orphan), 64'(1));
        do_reset(1);
        check("orphan_cleared", 64'(err_orphan), 64'(0));

        // random traffic phases with random engine latency
        for (int ph = 0; ph < 6; ph++) begin
            lat = $urandom_range(1, 6);
            repeat (40) step(4'($urandom_range(0, 15)), 1'b0);
            drain();
        end

        // asynchronous reset with operations outstanding
        lat = 20;
        repeat (5) step(4'b1111, 1'b0);
        check("pre_reset_inflight", 64'(inflight), 64'(5));
        do_reset(1);
        step(4'b1111, 1'b0);
        check("post_reset_grant", 64'(m_last), 64'(0));
        drain();
        check("late_result_orphan", 64'(err_orphan), 64'(1));
        do_reset(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
